// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, trained from ID resolution.
// Optional BP_STATS_EN adds resolved-branch and mispredict counters.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              id_hold,
  input  logic              id_flush,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] recover_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_d    [ENTRIES];

  logic              p_taken_q, p_taken_d;
  logic [ADDR_W-1:0] p_target_q, p_target_d;

  logic [IDX_W-1:0]  if_idx, res_idx;
  logic [TAG_W-1:0]  if_tag, res_tag;
  logic              if_hit, res_hit;
  logic              q, stale;
  logic              unused_low_bits;

  assign unused_low_bits = ^{pc_if[1:0], res_pc[1:0]};

  assign if_idx  = pc_if[IDX_W+1:2];
  assign if_tag  = pc_if[ADDR_W-1:IDX_W+2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign res_tag = res_pc[ADDR_W-1:IDX_W+2];

  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

  assign pred_taken   = if_hit & cnt_q[if_idx][CNT_W-1];
  assign pred_next_pc = pred_taken ? target_q[if_idx] : pc_if + ADDR_W'(4);

  assign q     = res_valid & ~id_hold;
  // A taken prediction reaching ID on a non-branch must redirect back to the fall-through path.
  assign stale = ~res_valid & ~id_hold & p_taken_q;

  assign mispredict = reset &
                      ((q & ((res_taken != p_taken_q) |
                             (res_taken & (res_target != p_target_q)))) | stale);
  assign recover_pc = (res_taken & res_valid) ? res_target : res_pc + ADDR_W'(4);

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    p_taken_d  = p_taken_q;
    p_target_d = p_target_q;

    if (!id_hold) begin
      if (id_flush) begin
        p_taken_d  = 1'b0;
        p_target_d = '0;
      end else begin
        p_taken_d  = pred_taken;
        p_target_d = pred_next_pc;
      end
    end

    if (q) begin
      if (res_hit) begin
        if (res_taken) begin
          target_d[res_idx] = res_target;
          if (cnt_q[res_idx] != CNT_MAX) cnt_d[res_idx] = cnt_q[res_idx] + CNT_W'(1);
        end else if (cnt_q[res_idx] != '0) begin
          cnt_d[res_idx] = cnt_q[res_idx] - CNT_W'(1);
        end
      end else if (res_taken) begin
        valid_d[res_idx]  = 1'b1;
        tag_d[res_idx]    = res_tag;
        target_d[res_idx] = res_target;
        cnt_d[res_idx]    = CNT_WT;
      end
    end else if (stale && res_hit) begin
      valid_d[res_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      p_taken_q  <= p_taken_d;
      p_target_q <= p_target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, q};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued per cycle and
// compared against combinational outputs mid-cycle.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        id_hold, id_flush;
  logic        res_valid, res_taken;
  logic [31:0] res_pc, res_target;
  logic        mispredict;
  logic [31:0] recover_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_if        (pc_if),
    .pred_taken   (pred_taken),
    .pred_next_pc (pred_next_pc),
    .id_hold      (id_hold),
    .id_flush     (id_flush),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .mispredict   (mispredict),
    .recover_pc   (recover_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {F_PT, F_NPC, F_MP, F_RPC, F_SB, F_SM} fld_e;
  typedef struct {
    fld_e        f;
    logic [31:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observe(input fld_e f);
    case (f)
      F_PT:  return {31'd0, pred_taken};
      F_NPC: return pred_next_pc;
      F_MP:  return {31'd0, mispredict};
      F_RPC: return recover_pc;
`ifdef BP_STATS_EN
      F_SB:  return stat_branches;
      F_SM:  return stat_mispredicts;
`endif
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input fld_e f, input logic [31:0] v);
    exp_t e;
    e.f = f;
    e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_pred(input logic t, input logic [31:0] npc);
    push(F_PT, {31'd0, t});
    push(F_NPC, npc);
  endtask

  task automatic exp_mp(input logic m, input logic [31:0] rpc);
    push(F_MP, {31'd0, m});
    if (m) push(F_RPC, rpc);
  endtask

  task automatic exp_stats(input logic [31:0] br, input logic [31:0] mp);
`ifdef BP_STATS_EN
    push(F_SB, br);
    push(F_SM, mp);
`else
    if (br === 32'hffff_ffff && mp === 32'hffff_ffff) $display("note: unexpected stats query");
`endif
  endtask

  task automatic drv(input logic [31:0] pc, input logic v, input logic [31:0] rp,
                     input logic t, input logic [31:0] tg);
    pc_if      = pc;
    res_valid  = v;
    res_pc     = rp;
    res_taken  = t;
    res_target = tg;
    id_hold    = 1'b0;
    id_flush   = 1'b0;
  endtask

  task automatic check_now();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("c%0d_%s", step, e.f.name()), observe(e.f), e.v);
    end
  endtask

  task automatic cyc();
    check_now();
    @(posedge clk);
    @(negedge clk);
    step++;
  endtask

  initial begin
    // Reset: resolution inputs active but everything must stay quiet.
    reset = 1'b0;
    drv(32'h40, 1, 32'h40, 1, 32'h80);
    exp_pred(0, 32'h44); exp_mp(0, 0); exp_stats(0, 0);
    cyc();
    reset = 1'b1;

    drv(32'h40, 0, 0, 0, 0);          exp_pred(0, 32'h44); exp_mp(0, 0); cyc();
    drv(32'h44, 1, 32'h40, 1, 32'h80); exp_pred(0, 32'h48); exp_mp(1, 32'h80); cyc();
    drv(32'h40, 0, 0, 0, 0);          exp_pred(1, 32'h80); exp_mp(0, 0); cyc();
    drv(32'h40, 1, 32'h40, 1, 32'h80); exp_pred(1, 32'h80); exp_mp(0, 0); cyc();

    // Counter walk down from 3: two not-taken still predict taken, third flips.
    drv(32'h40, 1, 32'h40, 0, 0);     exp_pred(1, 32'h80); exp_mp(1, 32'h44); cyc();
    drv(32'h40, 1, 32'h40, 0, 0);     exp_pred(1, 32'h80); exp_mp(1, 32'h44); cyc();
    drv(32'h40, 1, 32'h40, 0, 0);     exp_pred(0, 32'h44); exp_mp(1, 32'h44); cyc();
    drv(32'h40, 0, 0, 0, 0); id_flush = 1'b1;
    exp_pred(0, 32'h44); exp_mp(0, 0); cyc();

    // Aliasing on index 0.
    drv(32'h80, 1, 32'h80, 1, 32'h100); exp_pred(0, 32'h84); exp_mp(1, 32'h100); cyc();
    drv(32'h40, 0, 0, 0, 0);           exp_pred(0, 32'h44); exp_mp(0, 0); cyc();
    drv(32'h80, 0, 0, 0, 0);           exp_pred(1, 32'h100); exp_mp(0, 0); cyc();

    // Stall for 3 cycles with a pending not-taken resolution; flush during hold is ignored.
    for (int i = 0; i < 3; i++) begin
      drv(32'h80, 1, 32'h80, 0, 0);
      id_hold = 1'b1;
      if (i == 1) id_flush = 1'b1;
      exp_pred(1, 32'h100); exp_mp(0, 0); exp_stats(6, 5);
      cyc();
    end
    drv(32'h80, 1, 32'h80, 0, 0);       exp_pred(1, 32'h100); exp_mp(1, 32'h84); cyc();
    drv(32'h80, 1, 32'h80, 1, 32'h100); exp_pred(0, 32'h84); exp_mp(0, 0); exp_stats(7, 6); cyc();
    drv(32'h80, 0, 0, 0, 0);           exp_pred(1, 32'h100); exp_mp(0, 0); cyc();

    // Flush without hold clears the carried prediction.
    drv(32'h80, 1, 32'h80, 1, 32'h100); id_flush = 1'b1;
    exp_pred(1, 32'h100); exp_mp(0, 0); cyc();
    drv(32'h200, 1, 32'h80, 1, 32'h100); exp_pred(0, 32'h204); exp_mp(1, 32'h100); cyc();

    // Stale taken prediction on a non-branch invalidates the entry.
    drv(32'h80, 0, 0, 0, 0);           exp_pred(1, 32'h100); exp_mp(0, 0); cyc();
    drv(32'h300, 0, 32'h80, 0, 0);     exp_pred(0, 32'h304); exp_mp(1, 32'h84); cyc();
    drv(32'h80, 0, 0, 0, 0);           exp_pred(0, 32'h84); exp_mp(0, 0); exp_stats(10, 8); cyc();

    // Mid-run reset during a stall with a taken prediction in flight.
    drv(32'h40, 1, 32'h40, 1, 32'h80);  exp_pred(0, 32'h44); exp_mp(1, 32'h80); cyc();
    drv(32'h40, 0, 0, 0, 0);           exp_pred(1, 32'h80); exp_mp(0, 0); cyc();
    drv(32'h40, 0, 32'h40, 0, 0);      exp_mp(1, 32'h44); check_now();
    id_hold = 1'b1;
    reset   = 1'b0;
    exp_pred(0, 32'h44); exp_mp(0, 0); exp_stats(0, 0);
    cyc();
    reset = 1'b1;
    drv(32'h40, 0, 32'h40, 0, 0);      exp_pred(0, 32'h44); exp_mp(0, 0); cyc();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage pipeline: a direct-mapped branch target buffer (BTB) with saturating direction counters. It is looked up combinationally with the IF-stage PC, carries its prediction through a private IF/ID-aligned register, and is trained by the branch/jump resolution performed in ID. It replaces the static predict-not-taken "flush on taken" path with a predicted next PC plus a mispredict/recovery pair.

## Interface
- ADDR_W, 32, PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width; at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_if  in  ADDR_W  PC currently being fetched.
- pred_taken  out  1  IF prediction: taken.
- pred_next_pc  out  ADDR_W  predicted next fetch PC.
- id_hold  in  1  IF/ID hold (stall); same meaning as the IF/ID register's hold.
- id_flush  in  1  IF/ID flush.
- res_valid  in  1  instruction in ID is a branch or jump, resolved this cycle.
- res_pc  in  ADDR_W  PC of the instruction in ID.
- res_taken  in  1  resolved direction; always 1 for jumps.
- res_target  in  ADDR_W  resolved target address.
- mispredict  out  1  ID outcome differs from the carried prediction; redirect fetch and flush IF/ID.
- recover_pc  out  ADDR_W  correct next PC when mispredict=1.
- stat_branches  out  32  resolved-branch count (BP_STATS_EN only).
- stat_mispredicts  out  32  mispredict count (BP_STATS_EN only).

## Operation
- Indexing: idx = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2]. Bits [1:0] are ignored.
- Each entry holds valid, tag, target (ADDR_W) and cnt (CNT_W).
- Lookup is combinational.
  - hit = valid[idx] & tag match.
  - pred_taken = hit & cnt[idx][CNT_W-1].
  - pred_next_pc = pred_taken ? target[idx] : pc_if + 4, modulo 2^ADDR_W.
- Stage register (p_taken, p_target) on each edge:
  - id_hold=1: hold. Hold takes priority over flush.
  - id_hold=0 and id_flush=1: clear to 0/0.
  - Otherwise: capture pred_taken, pred_next_pc.
- Resolution is qualified by q = res_valid & ~id_hold.
  - mispredict = q & ((res_taken != p_taken) | (res_taken & (res_target != p_target))), or ~res_valid & ~id_hold & p_taken. The latter is a stale prediction on a non-branch.
  - recover_pc = res_taken & res_valid ? res_target : res_pc + 4.
- Training happens on the edge when q=1, at idx/tag of res_pc.
  - Hit, taken: cnt saturating increment (max 2^CNT_W-1); target <= res_target.
  - Hit, not taken: cnt saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate (replace any occupant): valid=1, tag, target=res_target, cnt=2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Stale-prediction mispredict (non-branch in ID with p_taken=1): invalidate the entry at res_pc's index if its tag matches.

## Timing
- Lookup: 0-cycle latency, pc_if to pred_*.
- Prediction reaches the ID comparison exactly 1 cycle after fetch, aligned with the IF/ID register.
- mispredict/recover_pc: combinational in the ID cycle. The consumer flushes IF/ID, which clears p_* on the next edge.
- Training is visible to lookups from the cycle after the update edge. A same-cycle lookup and update on one index returns the old contents.
- Reset (asynchronous, any time including mid-stall):
  - all valid=0; cnt=2^(CNT_W-1)-1; targets and tags 0.
  - p_taken=0, p_target=0; stat counters 0.
  - Outputs during reset: pred_taken=0, pred_next_pc=pc_if+4, mispredict=0.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each q=1 edge.
  - stat_mispredicts increments on each edge where mispredict=1.
  - Both are 32-bit and wrap from 2^32-1 to 0.
- BP_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, pc_if=0x40 -> pred_taken=0, pred_next_pc=0x44; assert reset mid-run -> all entries invalid and p_* = 0 immediately.
- Cold taken branch at 0x40 to 0x80: res_valid=1, res_taken=1 -> mispredict=1, recover_pc=0x80. Next fetch of 0x40 -> pred_taken=1, pred_next_pc=0x80. Re-resolve as taken -> mispredict=0.
- Counter saturation, CNT_W=2: entry trained to cnt=3; one not-taken -> cnt=2, still predicts taken. Second not-taken -> cnt=1, pred_next_pc=0x44. Each not-taken resolution while predicting taken gives mispredict=1, recover_pc=0x44.
- Aliasing, ENTRIES=16: taken branches at 0x40 and 0x80 (same idx 0). Second allocation replaces the first; fetch of 0x40 -> miss, pred_next_pc=0x44.
- Stall: id_hold=1 with res_valid=1 for 3 cycles, then released -> exactly one training update. mispredict=0 during the hold. With BP_STATS_EN, stat_branches increments by 1.
- Hold beats flush: id_hold=1, id_flush=1 with p_taken=1 -> p_taken stays 1. Flush with hold=0 -> p_taken=0.
